// File: rtl/placar_pkg.sv
// Shared definitions for the scoreboard digit recogniser.
// - state_t      : FSM state encoding
// - SEG7         : seven-segment code per digit (bit0=a .. bit6=g)
// - cnt_width    : width of a mismatch counter for a WxH glyph
// - template_bit : reference bitmap pixel for a digit at (row, col)
package placar_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_RECV, ST_DECIDE, ST_DONE} state_t;

  localparam int unsigned NUM_TEMPLATES = 10;

  localparam logic [6:0] SEG7 [NUM_TEMPLATES] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  function automatic int cnt_width(input int w, input int h);
    return $clog2(w * h + 1);
  endfunction

  // Template bitmaps are drawn from the segment code: rows 0, h/2 and h-1
  // are the horizontal bars a/g/d across the full width; the vertical bars
  // f/b (upper half) and e/c (lower half) are three columns wide at each side.
  // The centre columns between the vertical bars are always background.
  function automatic logic template_bit(input int digit, input int row,
                                        input int col, input int w, input int h);
    logic [6:0] s;
    s = SEG7[digit];
    if (row == 0)     return s[0];
    if (row == h - 1) return s[3];
    if (row == h / 2) return s[6];
    if (col < 3)      return (row < h / 2) ? s[5] : s[4];
    if (col >= w - 3) return (row < h / 2) ? s[1] : s[2];
    return 1'b0;
  endfunction

endpackage

// File: rtl/placar_reconhecedor_if.sv
// Pixel stream channel into the recogniser.
// - pixel_valid : source has a pixel this cycle
// - pixel_data  : pixel intensity
// - pixel_ready : sink accepts a pixel this cycle
interface placar_reconhecedor_if #(
  parameter int PIXEL_W = 8
);
  logic               pixel_valid;
  logic [PIXEL_W-1:0] pixel_data;
  logic               pixel_ready;

  modport master (output pixel_valid, output pixel_data, input pixel_ready);
  modport slave  (input pixel_valid, input pixel_data, output pixel_ready);
endinterface

// File: rtl/comparador_templates.sv
// Per-pixel compare-and-count against the ten digit templates.
// - clock/reset : rising-edge clock, synchronous active-high reset
// - clr         : zero all mismatch counters (start of a glyph)
// - en          : a binarised pixel is consumed this cycle
// - pbit        : binarised pixel value
// - row/col     : position of the pixel within the glyph
// - counts      : mismatch count per template, index = digit value
module comparador_templates
  import placar_pkg::*;
#(
  parameter int GLYPH_W = 11,
  parameter int GLYPH_H = 11,
  parameter int RW      = 4,
  parameter int CLW     = 4,
  parameter int CW      = 7
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                clr,
  input  logic                                en,
  input  logic                                pbit,
  input  logic [RW-1:0]                       row,
  input  logic [CLW-1:0]                      col,
  output logic [NUM_TEMPLATES-1:0][CW-1:0]    counts
);

  logic [NUM_TEMPLATES-1:0] tbit;

  always_comb begin
    tbit = '0;
    for (int unsigned d = 0; d < NUM_TEMPLATES; d++)
      tbit[d] = template_bit(int'(d), int'(row), int'(col), GLYPH_W, GLYPH_H);
  end

  always_ff @(posedge clock) begin
    if (reset || clr) begin
      counts <= '0;
    end else if (en) begin
      for (int unsigned d = 0; d < NUM_TEMPLATES; d++)
        counts[d] <= counts[d] + CW'(pbit ^ tbit[d]);
    end
  end

endmodule

// File: rtl/placar_reconhecedor.sv
// Scoreboard digit recogniser: binarises a pixel stream of NUM_DIGITS glyphs,
// matches each glyph against ten templates and reports the closest digit.
// - clock/reset  : rising-edge clock, synchronous active-high reset
// - start        : begin a scan (honoured only when idle)
// - flag         : inverted-glyph mode, latched at start
// - pix          : pixel stream (valid/data/ready)
// - digito       : digit k at bits [4k-1:4k-4], 4'hF when rejected
// - digito_valid : per-digit match-accepted flag
// - busy         : scan in progress
// - done         : one-cycle pulse at scan completion
module placar_reconhecedor
  import placar_pkg::*;
#(
  parameter int                 NUM_DIGITS = 7,
  parameter int                 GLYPH_W    = 11,
  parameter int                 GLYPH_H    = 11,
  parameter int                 PIXEL_W    = 8,
  parameter logic [PIXEL_W-1:0] THRESHOLD  = 8'd128,
  parameter int                 MAX_ERR    = 12
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    flag,
  placar_reconhecedor_if.slave    pix,
  output logic [4*NUM_DIGITS-1:0] digito,
  output logic [NUM_DIGITS-1:0]   digito_valid,
  output logic                    busy,
  output logic                    done
);

  localparam int CW  = cnt_width(GLYPH_W, GLYPH_H);
  localparam int RW  = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1;
  localparam int CLW = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;
  localparam int DW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  state_t                            state, nstate;
  logic                              flag_q;
  logic [RW-1:0]                     row;
  logic [CLW-1:0]                    col;
  logic [DW-1:0]                     dig;
  logic                              accept, pbit, clr, last_pix, last_dig;
  logic [NUM_TEMPLATES-1:0][CW-1:0]  counts;
  logic [CW-1:0]                     best_cnt;
  logic [3:0]                        best_val;

  assign pix.pixel_ready = (state == ST_RECV);
  assign busy            = (state != ST_IDLE);
  assign done            = (state == ST_DONE);

  assign accept   = pix.pixel_valid && pix.pixel_ready;
  assign pbit     = (pix.pixel_data >= THRESHOLD) ^ flag_q;
  assign last_pix = (row == RW'(GLYPH_H - 1)) && (col == CLW'(GLYPH_W - 1));
  assign last_dig = (dig == DW'(NUM_DIGITS - 1));
  assign clr      = ((state == ST_IDLE) && start) || (state == ST_DECIDE);

  comparador_templates #(
    .GLYPH_W (GLYPH_W),
    .GLYPH_H (GLYPH_H),
    .RW      (RW),
    .CLW     (CLW),
    .CW      (CW)
  ) u_cmp (
    .clock  (clock),
    .reset  (reset),
    .clr    (clr),
    .en     (accept),
    .pbit   (pbit),
    .row    (row),
    .col    (col),
    .counts (counts)
  );

  // Strict less-than keeps the lowest digit on ties.
  always_comb begin
    best_cnt = counts[0];
    best_val = '0;
    for (int unsigned d = 1; d < NUM_TEMPLATES; d++) begin
      if (counts[d] < best_cnt) begin
        best_cnt = counts[d];
        best_val = 4'(d);
      end
    end
  end

  always_comb begin
    nstate = state;
    unique case (state)
      ST_IDLE:   if (start) nstate = ST_RECV;
      ST_RECV:   if (accept && last_pix) nstate = ST_DECIDE;
      ST_DECIDE: nstate = last_dig ? ST_DONE : ST_RECV;
      ST_DONE:   nstate = ST_IDLE;
      default:   nstate = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      flag_q       <= 1'b0;
      row          <= '0;
      col          <= '0;
      dig          <= '0;
      digito       <= '1;
      digito_valid <= '0;
    end else begin
      state <= nstate;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            flag_q <= flag;
            row    <= '0;
            col    <= '0;
            dig    <= '0;
          end
        end
        ST_RECV: begin
          if (accept) begin
            if (col == CLW'(GLYPH_W - 1)) begin
              col <= '0;
              row <= last_pix ? '0 : row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        ST_DECIDE: begin
          if (best_cnt <= CW'(MAX_ERR)) begin
            digito[4*int'(dig) +: 4] <= best_val;
            digito_valid[dig]        <= 1'b1;
          end else begin
            digito[4*int'(dig) +: 4] <= 4'hF;
            digito_valid[dig]        <= 1'b0;
          end
          dig <= last_dig ? '0 : dig + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_placar_reconhecedor.sv
// Directed bench for placar_reconhecedor: clean, noisy, inverted, gapped and
// reset-interrupted scans with hand-computed digit fields and timings.
module tb_placar_reconhecedor;

  logic        clock = 1'b0;
  logic        reset, start, flag;
  logic [27:0] digito;
  logic [6:0]  digito_valid;
  logic        busy, done;
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          done_seen = 0;

  placar_reconhecedor_if #(.PIXEL_W(8)) pif ();

  placar_reconhecedor #(
    .NUM_DIGITS (7),
    .GLYPH_W    (11),
    .GLYPH_H    (11),
    .PIXEL_W    (8),
    .THRESHOLD  (8'd128),
    .MAX_ERR    (12)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .flag         (flag),
    .pix          (pif),
    .digito       (digito),
    .digito_valid (digito_valid),
    .busy         (busy),
    .done         (done)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) if (done) done_seen <= done_seen + 1;

  // Seven-segment glyph, pixel p = row*11 + col.
  function automatic logic [120:0] glyph(input int d);
    logic [6:0]   s;
    logic [120:0] g;
    g = '0;
    case (d)
      0: s = 7'h3F; 1: s = 7'h06; 2: s = 7'h5B; 3: s = 7'h4F; 4: s = 7'h66;
      5: s = 7'h6D; 6: s = 7'h7D; 7: s = 7'h07; 8: s = 7'h7F; 9: s = 7'h6F;
      default: s = 7'h00;
    endcase
    for (int r = 0; r < 11; r++) begin
      for (int c = 0; c < 11; c++) begin
        logic on;
        if (r == 0)       on = s[0];
        else if (r == 5)  on = s[6];
        else if (r == 10) on = s[3];
        else if (c < 3)   on = (r < 5) ? s[5] : s[4];
        else if (c > 7)   on = (r < 5) ? s[1] : s[2];
        else              on = 1'b0;
        g[r*11+c] = on;
      end
    end
    return g;
  endfunction

  // Flip the first n background (centre-column) pixels in row-major order.
  function automatic logic [120:0] bg_flip(input logic [120:0] g, input int n);
    int k;
    k = 0;
    for (int p = 0; p < 121; p++) begin
      int r, c;
      r = p / 11;
      c = p % 11;
      if (r != 0 && r != 5 && r != 10 && c >= 3 && c <= 7 && k < n) begin
        g[p] = ~g[p];
        k++;
      end
    end
    return g;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic feed_glyph(input logic [120:0] g, input logic [7:0] hi,
                            input logic [7:0] lo, input bit gaps,
                            input bit pulse_start, input int npix);
    for (int p = 0; p < npix; p++) begin
      int n;
      if (gaps) begin
        pif.pixel_valid = 1'b0;
        if (pulse_start && p == 0) start = 1'b1;
        tick();
        start = 1'b0;
      end
      pif.pixel_valid = 1'b1;
      pif.pixel_data  = g[p] ? hi : lo;
      n = 0;
      while (!pif.pixel_ready && n < 8) begin
        tick();
        n++;
      end
      if (!pif.pixel_ready) begin
        checks++; errors++;
        $display("FAIL pixel_ready_timeout: got 0 required 1 at pixel %0d", p);
        pif.pixel_valid = 1'b0;
        return;
      end
      tick();
    end
    pif.pixel_valid = 1'b0;
  endtask

  // t0 is the edge count just before the edge that samples start.
  task automatic start_scan(input bit flg, output int t0);
    t0 = cyc;
    start = 1'b1;
    flag = flg;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int tend);
    int i;
    i = 0;
    while (!done && i < 30) begin
      tick();
      i++;
    end
    tend = cyc;
    if (!done) begin
      checks++; errors++;
      $display("FAIL done_timeout: got done=0 required 1");
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; flag = 1'b0;
    pif.pixel_valid = 1'b0; pif.pixel_data = '0;
    tick(); tick(); tick();
    checks++; if (digito !== 28'hFFFFFFF) begin errors++; $display("FAIL reset_digito: got %h required fffffff", digito); end
    checks++; if (digito_valid !== 7'h00) begin errors++; $display("FAIL reset_valid: got %h required 00", digito_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b required 0", done); end
    checks++; if (pif.pixel_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b required 0", pif.pixel_ready); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_clean_scan();
    int t0, t1, d0;
    int seq[7] = '{3, 1, 4, 1, 5, 9, 2};
    d0 = done_seen;
    start_scan(1'b0, t0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clean_busy: got %b required 1", busy); end
    // Pixels at exactly the threshold count as ink, one below as paper.
    feed_glyph(glyph(seq[0]), 8'd128, 8'd127, 1'b0, 1'b0, 121);
    checks++; if (digito[3:0] !== 4'hF) begin errors++; $display("FAIL clean_decide_hold: got %h required f", digito[3:0]); end
    checks++; if (pif.pixel_ready !== 1'b0) begin errors++; $display("FAIL clean_decide_ready: got %b required 0", pif.pixel_ready); end
    tick();
    checks++; if (digito[3:0] !== 4'h3) begin errors++; $display("FAIL clean_digit1: got %h required 3", digito[3:0]); end
    checks++; if (digito_valid[0] !== 1'b1) begin errors++; $display("FAIL clean_valid1: got %b required 1", digito_valid[0]); end
    for (int k = 1; k < 7; k++) feed_glyph(glyph(seq[k]), 8'd128, 8'd127, 1'b0, 1'b0, 121);
    wait_done(t1);
    checks++; if (t1 - t0 !== 855) begin errors++; $display("FAIL clean_latency: got %0d required 855", t1 - t0); end
    checks++; if (digito !== 28'h2951413) begin errors++; $display("FAIL clean_digito: got %h required 2951413", digito); end
    checks++; if (digito_valid !== 7'h7F) begin errors++; $display("FAIL clean_valid: got %h required 7f", digito_valid); end
    tick();
    checks++; if (done_seen - d0 !== 1) begin errors++; $display("FAIL clean_done_pulses: got %0d required 1", done_seen - d0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clean_idle_busy: got %b required 0", busy); end
  endtask

  task automatic test_noise();
    int t0, t1;
    logic [120:0] g[7];
    g[0] = glyph(8);
    g[0][0] = ~g[0][0]; g[0][12] = ~g[0][12]; g[0][60] = ~g[0][60];
    g[0][61] = ~g[0][61]; g[0][120] = ~g[0][120];
    g[1] = bg_flip(glyph(8), 40);
    g[2] = bg_flip(glyph(8), 12);
    g[3] = bg_flip(glyph(8), 13);
    // Nine with half its upper-left bar missing: six errors against both 3 and 9.
    g[4] = glyph(9);
    g[4][11] = 1'b0; g[4][12] = 1'b0; g[4][13] = 1'b0;
    g[4][22] = 1'b0; g[4][23] = 1'b0; g[4][24] = 1'b0;
    g[5] = glyph(6);
    g[6] = glyph(7);
    start_scan(1'b0, t0);
    feed_glyph(g[0], 8'd255, 8'd0, 1'b0, 1'b0, 121);
    tick();
    checks++; if (digito[3:0] !== 4'h8) begin errors++; $display("FAIL noise5_digit: got %h required 8", digito[3:0]); end
    checks++; if (digito[27:4] !== 24'h295141) begin errors++; $display("FAIL noise_keep_prior: got %h required 295141", digito[27:4]); end
    checks++; if (digito_valid !== 7'h7F) begin errors++; $display("FAIL noise_keep_valid: got %h required 7f", digito_valid); end
    for (int k = 1; k < 7; k++) feed_glyph(g[k], 8'd255, 8'd0, 1'b0, 1'b0, 121);
    wait_done(t1);
    checks++; if (digito !== 28'h763F8F8) begin errors++; $display("FAIL noise_digito: got %h required 763f8f8", digito); end
    checks++; if (digito_valid !== 7'h75) begin errors++; $display("FAIL noise_valid: got %h required 75", digito_valid); end
    tick();
  endtask

  task automatic test_inverted();
    int t0, t1;
    start_scan(1'b1, t0);
    for (int k = 0; k < 7; k++) begin
      if (k == 3) flag = 1'b0;
      feed_glyph(glyph(k), 8'd0, 8'd255, 1'b0, 1'b0, 121);
    end
    wait_done(t1);
    checks++; if (digito !== 28'h6543210) begin errors++; $display("FAIL inverted_digito: got %h required 6543210", digito); end
    checks++; if (digito_valid !== 7'h7F) begin errors++; $display("FAIL inverted_valid: got %h required 7f", digito_valid); end
    tick();
  endtask

  task automatic test_back_to_back_gaps();
    int t0, t1;
    int seq[7] = '{3, 1, 4, 1, 5, 9, 2};
    start_scan(1'b0, t0);
    for (int k = 0; k < 7; k++)
      feed_glyph(glyph(seq[k]), 8'd200, 8'd50, 1'b1, k == 2, 121);
    wait_done(t1);
    // Each pixel costs two edges; the DECIDE cycle overlaps the next idle beat.
    checks++; if (t1 - t0 !== 1696) begin errors++; $display("FAIL gaps_latency: got %0d required 1696", t1 - t0); end
    checks++; if (digito !== 28'h2951413) begin errors++; $display("FAIL gaps_digito: got %h required 2951413", digito); end
    checks++; if (digito_valid !== 7'h7F) begin errors++; $display("FAIL gaps_valid: got %h required 7f", digito_valid); end
    tick();
  endtask

  task automatic test_reset_mid_scan();
    int t0, t1;
    int seq[7] = '{8, 7, 6, 5, 4, 3, 2};
    start_scan(1'b0, t0);
    feed_glyph(glyph(3), 8'd255, 8'd0, 1'b0, 1'b0, 121);
    feed_glyph(glyph(1), 8'd255, 8'd0, 1'b0, 1'b0, 121);
    feed_glyph(glyph(4), 8'd255, 8'd0, 1'b0, 1'b0, 121);
    tick();
    checks++; if (digito[11:0] !== 12'h413) begin errors++; $display("FAIL midreset_pre: got %h required 413", digito[11:0]); end
    feed_glyph(glyph(1), 8'd255, 8'd0, 1'b0, 1'b0, 10);
    reset = 1'b1; start = 1'b1; pif.pixel_valid = 1'b1;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b required 0", busy); end
    checks++; if (digito !== 28'hFFFFFFF) begin errors++; $display("FAIL midreset_digito: got %h required fffffff", digito); end
    checks++; if (digito_valid !== 7'h00) begin errors++; $display("FAIL midreset_valid: got %h required 00", digito_valid); end
    checks++; if (pif.pixel_ready !== 1'b0) begin errors++; $display("FAIL midreset_ready: got %b required 0", pif.pixel_ready); end
    reset = 1'b0; start = 1'b0; pif.pixel_valid = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_idle: got %b required 0", busy); end
    start_scan(1'b0, t0);
    for (int k = 0; k < 7; k++) feed_glyph(glyph(seq[k]), 8'd255, 8'd0, 1'b0, 1'b0, 121);
    wait_done(t1);
    checks++; if (t1 - t0 !== 855) begin errors++; $display("FAIL rescan_latency: got %0d required 855", t1 - t0); end
    checks++; if (digito !== 28'h2345678) begin errors++; $display("FAIL rescan_digito: got %h required 2345678", digito); end
    checks++; if (digito_valid !== 7'h7F) begin errors++; $display("FAIL rescan_valid: got %h required 7f", digito_valid); end
    tick();
  endtask

  initial begin
    test_reset();
    test_clean_scan();
    test_noise();
    test_inverted();
    test_back_to_back_gaps();
    test_reset_mid_scan();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/placar_reconhecedor.md
PLACAR_RECONHECEDOR -- requirements
Module: placar_reconhecedor

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 7, number of scoreboard digit positions.
REQ-002 SHALL have parameter GLYPH_W, default 11, glyph width in pixels.
REQ-003 SHALL have parameter GLYPH_H, default 11, glyph height in pixels.
REQ-004 SHALL have parameter PIXEL_W, default 8, pixel intensity width.
REQ-005 SHALL have parameter THRESHOLD, default 8'd128, binarisation level.
REQ-006 SHALL have parameter MAX_ERR, default 12, maximum mismatches accepted for a valid match.
REQ-007 SHALL have port clock  input  1  sole clock, all logic on rising edge.
REQ-008 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-009 SHALL have port start  input  1  one-cycle request to begin a scoreboard scan.
REQ-010 SHALL have port flag  input  1  inverted-glyph mode, sampled at accepted start.
REQ-011 SHALL have port pixel_valid  input  1  pixel_data is valid this cycle.
REQ-012 SHALL have port pixel_data  input  PIXEL_W  pixel intensity, digit 1 first, row-major within each glyph.
REQ-013 SHALL have port pixel_ready  output  1  block accepts a pixel this cycle.
REQ-014 SHALL have port digito  output  4*NUM_DIGITS  recognised digits, digit k at bits [4k-1:4k-4], k = 1..NUM_DIGITS.
REQ-015 SHALL have port digito_valid  output  NUM_DIGITS  per-digit match-accepted flag.
REQ-016 SHALL have port busy  output  1  scan in progress.
REQ-017 SHALL have port done  output  1  one-cycle pulse when a scan completes.

Function
REQ-018 SHALL implement states IDLE, RECV, DECIDE, DONE; reset enters IDLE.
REQ-019 In IDLE, start=1 SHALL latch flag, clear pixel and digit counters, and enter RECV next cycle; start outside IDLE SHALL be ignored.
REQ-020 pixel_ready SHALL be 1 only in RECV; a pixel is consumed only when pixel_valid and pixel_ready are both 1.
REQ-021 Each consumed pixel SHALL be binarised to 1 when pixel_data >= THRESHOLD, then inverted when latched flag=1.
REQ-022 For each of 10 templates (digits 0-9), a mismatch counter of width clog2(GLYPH_W*GLYPH_H+1) SHALL increment when the binarised pixel differs from the template bit; counters clear at the start of each glyph.
REQ-023 After the GLYPH_W*GLYPH_H-th pixel of a glyph, the block SHALL enter DECIDE for exactly one cycle, with pixel_ready=0.
REQ-024 In DECIDE the template with minimum mismatch count SHALL be selected; ties SHALL resolve to the lowest digit value.
REQ-025 If minimum count <= MAX_ERR, the current digit field SHALL take the selected value and its digito_valid bit SHALL be 1; otherwise the field SHALL be 4'hF and the valid bit 0.
REQ-026 From DECIDE the block SHALL return to RECV if more digits remain, else enter DONE.
REQ-027 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-028 busy SHALL be 1 in RECV, DECIDE and DONE, and 0 in IDLE.
REQ-029 digito and digito_valid SHALL hold their values until overwritten by a later DECIDE; fields not yet rewritten in a new scan keep prior values.
REQ-030 Latency from the last pixel of digit k to its update SHALL be 2 cycles (DECIDE, then registered output); the done pulse SHALL follow the last digit update by 0 cycles (same cycle as DONE state).
REQ-031 pixel_valid gaps SHALL stall counting without error; there SHALL be no timeout.

Reset
REQ-032 reset=1 SHALL at the next edge force IDLE, digito to all 4'hF, digito_valid to 0, busy, done and pixel_ready to 0, and clear all counters, including mid-scan.
REQ-033 reset SHALL take priority over start and pixel_valid in the same cycle.

Structure
REQ-034 The 10 template bitmaps, state encoding and the clog2-based count width SHALL live in shared package placar_pkg.
REQ-035 The per-pixel compare-and-count logic for the 10 templates SHALL be the sub-module comparador_templates; FSM, counters and output registers SHALL be in placar_reconhecedor.

Verification
REQ-036 Scan of 7 clean glyphs 3,1,4,1,5,9,2 with pixel_valid held high -> digito = 2,9,5,1,4,1,3 (digit 7..1), digito_valid=7'h7F, done one pulse exactly 7*122+1 cycles after start.
REQ-037 Glyph 8 with 5 flipped pixels -> field = 8, valid=1; same glyph with 40 random flips -> field = 4'hF, valid=0.
REQ-038 flag=1 with colour-inverted glyphs of 0..6 -> same digits as non-inverted scan; flag toggled mid-scan has no effect.
REQ-039 pixel_valid toggled 1/0 every cycle -> identical digito to REQ-036, scan time doubled for pixel phases; start pulsed mid-scan is ignored.
REQ-040 reset asserted after 3 digits recognised -> next cycle IDLE, digito all 4'hF, digito_valid=0, busy=0; new start then scans normally.
